// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit slice: receiver state
// encoding, character width and the bit-period helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Whole clock cycles per line bit; the fractional part is dropped.
  function automatic int cycles_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Byte stream leaving the UART receiver: head-of-buffer byte with a
// valid/ready handshake plus the current buffer occupancy.
interface uart_byte_receiver_if #(
  parameter int FIFO_DEPTH = 4
);
  import uart_pkg::*;

  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic [UART_DATA_BITS-1:0] data_out;
  logic                      data_out_valid;
  logic                      data_out_ready;
  logic [COUNT_WIDTH-1:0]    fifo_count;

  modport master (
    output data_out,
    output data_out_valid,
    output fifo_count,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  fifo_count,
    output data_out_ready
  );

endinterface

// File: rtl/uart_byte_receiver_fifo.sv
// First-word-fall-through byte buffer shared by the UART receive and
// transmit paths. A push into a full buffer only lands when a pop frees
// a slot in the same cycle; otherwise it is ignored.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]     storage [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = empty ? '0 : storage[rd_ptr];

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronises the line, samples each bit at its
// centre, buffers completed bytes and reports framing/overrun pulses.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        uart_receive,
  uart_byte_receiver_if.master        stream,
  output logic                        busy,
  output logic                        framing_error,
  output logic                        overrun_error
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int COUNTER_WIDTH  = $clog2(CYCLES_PER_BIT);
  localparam int INDEX_WIDTH    = $clog2(UART_DATA_BITS);

  localparam logic [COUNTER_WIDTH-1:0] HALF_BIT_LOAD = COUNTER_WIDTH'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [COUNTER_WIDTH-1:0] FULL_BIT_LOAD = COUNTER_WIDTH'(CYCLES_PER_BIT - 1);
  localparam logic [INDEX_WIDTH-1:0]   LAST_INDEX    = INDEX_WIDTH'(UART_DATA_BITS - 1);

  logic sync_meta;
  logic rx_s;

  rx_state_t                 state;
  rx_state_t                 state_next;
  logic [COUNTER_WIDTH-1:0]  bit_counter;
  logic [COUNTER_WIDTH-1:0]  bit_counter_next;
  logic [INDEX_WIDTH-1:0]    bit_index;
  logic [INDEX_WIDTH-1:0]    bit_index_next;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_reg_next;
  logic                      push_pending;
  logic                      push_next;
  logic                      framing_next;

  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign busy                  = (state != IDLE);
  assign stream.data_out_valid = !fifo_empty;
  assign pop                   = stream.data_out_valid && stream.data_out_ready;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= uart_receive;
      rx_s      <= sync_meta;
    end
  end

  // Receiver state, bit timing and assembly registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bit_counter   <= '0;
      bit_index     <= '0;
      shift_reg     <= '0;
      push_pending  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      bit_counter   <= bit_counter_next;
      bit_index     <= bit_index_next;
      shift_reg     <= shift_reg_next;
      push_pending  <= push_next;
      framing_error <= framing_next;
    end
  end

  // Frame decoding: half a bit to the centre of the start bit, then one
  // full bit period between every following sample.
  always_comb begin
    state_next       = state;
    bit_counter_next = bit_counter;
    bit_index_next   = bit_index;
    shift_reg_next   = shift_reg;
    push_next        = 1'b0;
    framing_next     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next       = START;
          bit_counter_next = HALF_BIT_LOAD;
        end
      end
      START: begin
        if (bit_counter != '0) begin
          bit_counter_next = bit_counter - 1'b1;
        end else if (!rx_s) begin
          state_next       = DATA;
          bit_counter_next = FULL_BIT_LOAD;
          bit_index_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      DATA: begin
        if (bit_counter != '0) begin
          bit_counter_next = bit_counter - 1'b1;
        end else begin
          shift_reg_next[bit_index] = rx_s;
          bit_counter_next          = FULL_BIT_LOAD;
          if (bit_index == LAST_INDEX) begin
            state_next = STOP;
          end else begin
            bit_index_next = bit_index + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_counter != '0) begin
          bit_counter_next = bit_counter - 1'b1;
        end else if (rx_s) begin
          push_next  = 1'b1;
          state_next = IDLE;
        end else begin
          framing_next = 1'b1;
          state_next   = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A completed byte arriving at a full buffer with no pop is lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= push_pending && fifo_full && !pop;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_byte_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_pending),
    .push_data (shift_reg),
    .pop       (pop),
    .head_data (stream.data_out),
    .count     (stream.fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Bench for uart_byte_receiver: directed scenarios plus random frames,
// checked against a byte-level queue model of the receive buffer.
module tb_uart_byte_receiver;

  localparam int CLOCK_FREQUENCY = 100;
  localparam int BAUD_RATE       = 10;
  localparam int FIFO_DEPTH      = 4;
  localparam int BIT_TIME        = 100;

  logic clock;
  logic reset;
  logic uart_receive;
  logic busy;
  logic framing_error;
  logic overrun_error;

  uart_byte_receiver_if #(.FIFO_DEPTH(FIFO_DEPTH)) stream ();

  uart_byte_receiver #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .BAUD_RATE       (BAUD_RATE),
    .FIFO_DEPTH      (FIFO_DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .uart_receive  (uart_receive),
    .stream        (stream),
    .busy          (busy),
    .framing_error (framing_error),
    .overrun_error (overrun_error)
  );

  int compared_count;
  int mismatch_count;

  logic [7:0] exp_q [$];
  int exp_overruns;
  int exp_framings;
  int seen_overruns;
  int seen_framings;
  int pops_seen;
  int valid_cycles;
  logic prev_fe;
  logic prev_oe;
  logic [7:0] last_popped;
  logic [7:0] bp_bytes [4];
  logic [7:0] partial_byte;

  // 10-unit clock period gives 10 clocks per 100-unit bit.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Last-resort guard so the run can never hang.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model of the buffer: a byte whose stop bit is good enters the queue
  // unless the buffer already holds FIFO_DEPTH bytes.
  task automatic modelPush(input logic [7:0] value);
    if (exp_q.size() >= FIFO_DEPTH) begin
      exp_overruns++;
    end else begin
      exp_q.push_back(value);
    end
  endtask

  task automatic alignDrive();
    @(posedge clock);
    #1;
  endtask

  // One 8N1 frame, LSB first; a bad frame holds the stop bit low for two bits.
  task automatic applyStimulus(input logic [7:0] value, input bit good_stop);
    alignDrive();
    uart_receive = 1'b0;
    #BIT_TIME;
    for (int i = 0; i < 8; i++) begin
      uart_receive = value[i];
      if (i == 0) begin
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
      end
      #BIT_TIME;
    end
    if (good_stop) begin
      uart_receive = 1'b1;
      modelPush(value);
      #BIT_TIME;
    end else begin
      uart_receive = 1'b0;
      exp_framings++;
      #(2 * BIT_TIME);
      uart_receive = 1'b1;
    end
    #(2 * BIT_TIME);
  endtask

  task automatic checkpoint(input string tag);
    checkOutput({tag, "_framings"}, 32'(seen_framings), 32'(exp_framings));
    checkOutput({tag, "_overruns"}, 32'(seen_overruns), 32'(exp_overruns));
    checkOutput({tag, "_count"}, 32'(stream.fifo_count), 32'(exp_q.size()));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drainAll(input string tag);
    alignDrive();
    stream.data_out_ready = 1'b1;
    repeat (2 * FIFO_DEPTH + 4) @(posedge clock);
    #1;
    checkOutput({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle comparison of the stream against the model and the
  // output invariants, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      prev_fe = 1'b0;
      prev_oe = 1'b0;
    end else begin
      checkOutput("valid_vs_count", 32'(stream.data_out_valid), 32'(stream.fifo_count != '0));
      if (!stream.data_out_valid) begin
        checkOutput("empty_data_zero", 32'(stream.data_out), 32'd0);
      end
      checkOutput("count_range", 32'(stream.fifo_count <= FIFO_DEPTH), 32'd1);
      checkOutput("errors_exclusive", 32'(framing_error && overrun_error), 32'd0);
      checkOutput("framing_width", 32'(framing_error && prev_fe), 32'd0);
      checkOutput("overrun_width", 32'(overrun_error && prev_oe), 32'd0);
      if (framing_error) seen_framings++;
      if (overrun_error) seen_overruns++;
      if (stream.data_out_valid) valid_cycles++;
      if (stream.data_out_valid && stream.data_out_ready) begin
        if (exp_q.size() == 0) begin
          compared_count++;
          mismatch_count++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", stream.data_out);
        end else begin
          checkOutput("stream_byte", 32'(stream.data_out), 32'(exp_q.pop_front()));
        end
        last_popped = stream.data_out;
        pops_seen++;
      end
      prev_fe = framing_error;
      prev_oe = overrun_error;
    end
  end

  // Directed scenarios followed by a randomized frame sequence.
  initial begin
    int pops_before;
    int valid_before;
    int fe_before;
    int ovr_before;
    logic [7:0] rand_byte;

    compared_count = 0;
    mismatch_count = 0;
    exp_overruns   = 0;
    exp_framings   = 0;
    seen_overruns  = 0;
    seen_framings  = 0;
    pops_seen      = 0;
    valid_cycles   = 0;
    last_popped    = 8'h00;
    prev_fe        = 1'b0;
    prev_oe        = 1'b0;
    bp_bytes       = '{8'h11, 8'h22, 8'h33, 8'h44};
    partial_byte   = 8'h07;
    reset          = 1'b0;
    uart_receive   = 1'b1;
    stream.data_out_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_valid", 32'(stream.data_out_valid), 32'd0);
    checkOutput("reset_data", 32'(stream.data_out), 32'd0);
    checkOutput("reset_count", 32'(stream.fifo_count), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_framing", 32'(framing_error), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_error), 32'd0);
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    $display("[TB] single byte");
    stream.data_out_ready = 1'b1;
    valid_before = valid_cycles;
    applyStimulus(8'h11, 1'b1);
    checkOutput("single_valid_cycles", 32'(valid_cycles - valid_before), 32'd1);
    checkOutput("single_data", 32'(last_popped), 32'h11);
    checkpoint("single");

    $display("[TB] backpressure");
    stream.data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(bp_bytes[i], 1'b1);
    end
    checkOutput("bp_count_full", 32'(stream.fifo_count), 32'd4);
    checkpoint("bp");
    alignDrive();
    stream.data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("bp_drain_valid", 32'(stream.data_out_valid), 32'd1);
      checkOutput("bp_drain_data", 32'(stream.data_out), 32'(bp_bytes[i]));
    end
    @(negedge clock);
    checkOutput("bp_drained_count", 32'(stream.fifo_count), 32'd0);

    $display("[TB] overrun");
    alignDrive();
    stream.data_out_ready = 1'b0;
    ovr_before  = seen_overruns;
    pops_before = pops_seen;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h11 * (i + 1)), 1'b1);
    end
    checkOutput("ovr_pulses", 32'(seen_overruns - ovr_before), 32'd1);
    checkpoint("ovr");
    drainAll("ovr");
    checkOutput("ovr_pops", 32'(pops_seen - pops_before), 32'd4);
    checkOutput("ovr_last", 32'(last_popped), 32'h44);

    $display("[TB] framing error");
    fe_before    = seen_framings;
    valid_before = valid_cycles;
    applyStimulus(8'hA5, 1'b0);
    checkOutput("fe_pulses", 32'(seen_framings - fe_before), 32'd1);
    checkOutput("fe_no_valid", 32'(valid_cycles - valid_before), 32'd0);
    applyStimulus(8'h06, 1'b1);
    checkOutput("fe_next_byte", 32'(last_popped), 32'h06);
    checkpoint("fe");

    $display("[TB] glitch rejection");
    valid_before = valid_cycles;
    alignDrive();
    uart_receive = 1'b0;
    #30;
    uart_receive = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    checkOutput("glitch_no_valid", 32'(valid_cycles - valid_before), 32'd0);
    checkpoint("glitch");

    $display("[TB] reset mid-frame");
    stream.data_out_ready = 1'b0;
    applyStimulus(8'h31, 1'b1);
    applyStimulus(8'h32, 1'b1);
    checkOutput("rst_pre_count", 32'(stream.fifo_count), 32'd2);
    alignDrive();
    uart_receive = 1'b0;
    #BIT_TIME;
    for (int i = 0; i < 4; i++) begin
      uart_receive = partial_byte[i];
      #BIT_TIME;
    end
    uart_receive = partial_byte[4];
    #(BIT_TIME / 2);
    reset = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("rst_mid_valid", 32'(stream.data_out_valid), 32'd0);
    checkOutput("rst_mid_data", 32'(stream.data_out), 32'd0);
    checkOutput("rst_mid_count", 32'(stream.fifo_count), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_framing", 32'(framing_error), 32'd0);
    checkOutput("rst_mid_overrun", 32'(overrun_error), 32'd0);
    #49;
    uart_receive = 1'b1;
    #(3 * BIT_TIME);
    alignDrive();
    reset = 1'b1;
    #(2 * BIT_TIME);
    stream.data_out_ready = 1'b1;
    pops_before = pops_seen;
    applyStimulus(8'h08, 1'b1);
    checkOutput("rst_after_pops", 32'(pops_seen - pops_before), 32'd1);
    checkOutput("rst_after_byte", 32'(last_popped), 32'h08);
    checkpoint("rst");

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      alignDrive();
      stream.data_out_ready = 1'($urandom_range(0, 1));
      rand_byte = 8'($urandom_range(0, 255));
      applyStimulus(rand_byte, $urandom_range(0, 7) != 0);
    end
    drainAll("random");
    checkpoint("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- Upstream stage of the high-throughput test harness. Deserialises the host UART line (8N1, LSB first) into bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte stream to the array-packing logic.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
CLOCK_FREQUENCY, 100_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE (floor), must be >= 4
FIFO_DEPTH, 4, output buffer depth in bytes; power of two, >= 2

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset; 0 = in reset
uart_receive  input  1  asynchronous serial line, idle high
data_out  output  8  head-of-FIFO byte; 8'h00 when FIFO empty
data_out_valid  output  1  FIFO non-empty
data_out_ready  input  1  consumer accepts data_out when valid && ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
busy  output  1  receiver not in IDLE
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun_error  output  1  one-cycle pulse: completed byte dropped because FIFO full

Behaviour:
- Reset (reset=0, asynchronous): synchroniser flops = 1; state = IDLE; counters = 0; FIFO empty; all outputs 0 (data_out 8'h00, fifo_count 0).
- uart_receive passes through a 2-flop synchroniser. rx_s is the synchronised line; all decisions below use rx_s.
- FSM states and transitions:
  - IDLE: rx_s==0 -> START, bit_counter loaded with CYCLES_PER_BIT/2 - 1.
  - START: counts down to 0, then samples rx_s. If rx_s==0 -> DATA, counter = CYCLES_PER_BIT-1, bit_index = 0. If rx_s==1 (glitch) -> IDLE, nothing reported.
  - DATA: at counter 0, shift_reg[bit_index] <= rx_s and reload the counter. After bit_index 7 is sampled -> STOP.
  - STOP: at counter 0, sample rx_s.
    - rx_s==1: push shift_reg into the FIFO -> IDLE.
    - rx_s==0: pulse framing_error, discard the byte -> BREAK.
  - BREAK: wait for rx_s==1 -> IDLE. This prevents a held-low line from retriggering.
- All samples are taken at mid-bit. The push occurs on the cycle after the stop-bit sample. data_out_valid rises the following cycle if the FIFO was empty.
- Push accounting:
  - Push when full with no pop that cycle: byte dropped, FIFO unchanged, overrun_error pulses for 1 cycle.
  - Push and pop in the same cycle: both take effect, including when full (push accepted, count unchanged).
- FIFO is first-word-fall-through. data_out reflects the head combinationally from registered storage. A pop occurs when data_out_valid && data_out_ready. data_out_ready while empty has no effect.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_count ranges 0..FIFO_DEPTH.
- busy = (state != IDLE).
- Reset asserted mid-byte: partial byte discarded, FIFO flushed. After release the receiver waits in IDLE for the next falling edge.
- framing_error and overrun_error cannot occur in the same cycle.

Decomposition:
- Shared package uart_pkg holds:
  - receiver state encoding typedef (IDLE, START, DATA, STOP, BREAK);
  - UART_DATA_BITS = 8;
  - function cycles_per_bit(clock_frequency, baud_rate).
- Sub-module byte_fifo (parameter DEPTH, WIDTH=8) implements the FWFT buffer with push/pop/count/full/empty. It is reused by the transmit side.

Test Plan:
All scenarios use CLOCK_FREQUENCY=100, BAUD_RATE=10 (10 cycles/bit), FIFO_DEPTH=4, with a 100-time-unit bit period driven from the bench.
- Single byte, ready held 1: send 8'h11 -> data_out_valid high for exactly 1 cycle with data_out=8'h11; no error pulses; busy returns to 0.
- Backpressure: ready=0, send 8'h11, 8'h22, 8'h33, 8'h44 -> fifo_count=4. Then ready=1 -> bytes drain in order 11,22,33,44 on 4 consecutive cycles, fifo_count returns to 0.
- Overrun: ready=0, send 11,22,33,44,55 -> one overrun_error pulse after the fifth stop bit. Draining yields only 11,22,33,44.
- Framing error: send 8'hA5 with the stop bit driven 0 for 2 bit times, then idle -> framing_error pulses once, no valid. A following 8'h06 is received correctly.
- Glitch rejection: drive uart_receive low for 3 clock cycles, then high -> returns to IDLE after the START sample; no valid, no errors, fifo_count=0.
- Reset mid-frame: assert reset during bit 4 of 8'h07 with 2 bytes already buffered -> all outputs 0 immediately. After release, a sent 8'h08 is the only byte received.
